rx_bit_timer: RTL and testbench

- Parametrised next-generation receive timing controller for the USB receiver.
- Recovers bit timing from decoded-data edges and re-aligns its sample phase on every edge.
- Generates one shift_enable per data bit, removes stuffed bits after 6 consecutive ones, flags stuff errors, and pulses byte_received every BITS_PER_BYTE kept bits.
- Sits between the edge detector/NRZI decoder and the receive shift register.

---
 rtl/usb_rx_pkg.sv | 13 +
 rtl/rx_stuff_detector.sv | 47 ++++
 rtl/rx_bit_timer.sv | 121 ++++++++++++
 tb/tb_rx_bit_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive datapath.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } rx_timer_state_t;

  localparam int USB_CLKS_PER_BIT = 8;
  localparam int USB_STUFF_LEN    = 6;

endpackage

// File: rtl/rx_stuff_detector.sv
// Counts consecutive sampled ones and marks the bit after STUFF_LEN ones as a stuff bit.
module rx_stuff_detector
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic sample,
  input  logic d_orig,
  output logic is_stuff,
  output logic stuff_error
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);

  logic [OW-1:0] ones_cnt_reg;
  logic [OW-1:0] ones_cnt_next;

  assign is_stuff    = (ones_cnt_reg == STUFF_MAX);
  assign stuff_error = sample && is_stuff && d_orig;

  // Increments only happen below STUFF_MAX, so the count saturates there.
  always_comb begin
    ones_cnt_next = ones_cnt_reg;
    if (clear) begin
      ones_cnt_next = '0;
    end else if (sample) begin
      if (is_stuff || !d_orig) begin
        ones_cnt_next = '0;
      end else begin
        ones_cnt_next = ones_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt_reg <= '0;
    end else begin
      ones_cnt_reg <= ones_cnt_next;
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// USB receive bit timer: edge-resynchronised sample phase, stuff-bit removal and byte framing.
module rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
  parameter int SAMPLE_POINT  = 3,
  parameter int BITS_PER_BYTE = 8,
  parameter int STUFF_LEN     = USB_STUFF_LEN
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               d_edge,
  input  logic                               d_orig,
  input  logic                               rx_transfer_active,
  output logic                               shift_enable,
  output logic                               byte_received,
  output logic                               stuff_error,
  output logic [$clog2(BITS_PER_BYTE+1)-1:0] bit_count
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(BITS_PER_BYTE + 1);
  localparam logic [PW-1:0] SAMPLE_PHASE = PW'(SAMPLE_POINT);
  localparam logic [PW-1:0] LAST_PHASE   = PW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT     = CW'(BITS_PER_BYTE - 1);

  rx_timer_state_t state_reg, state_next;
  logic [PW-1:0]   phase_reg, phase_next;
  logic [CW-1:0]   bit_count_reg, bit_count_next;

  logic sample_event;
  logic is_stuff;
  logic shift_int;
  logic byte_int;
  logic stuff_clear;

  // Gating by rst and rx_transfer_active keeps pulses off in reset and deassert cycles.
  assign sample_event = (state_reg == RUN) && (phase_reg == SAMPLE_PHASE) &&
                        rx_transfer_active && !rst;
  assign shift_int    = sample_event && !is_stuff;
  assign byte_int     = shift_int && (bit_count_reg == LAST_BIT);
  assign stuff_clear  = (state_reg != RUN) || !rx_transfer_active;

  rx_stuff_detector #(
    .STUFF_LEN(STUFF_LEN)
  ) u_stuff (
    .clk        (clk),
    .rst        (rst),
    .clear      (stuff_clear),
    .sample     (sample_event),
    .d_orig     (d_orig),
    .is_stuff   (is_stuff),
    .stuff_error(stuff_error)
  );

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    bit_count_next = bit_count_reg;
    unique case (state_reg)
      IDLE: begin
        phase_next     = '0;
        bit_count_next = '0;
        if (rx_transfer_active) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (!rx_transfer_active) begin
          state_next     = IDLE;
          phase_next     = '0;
          bit_count_next = '0;
        end else if (d_edge) begin
          state_next = RUN;
          phase_next = '0;
        end
      end
      RUN: begin
        if (!rx_transfer_active) begin
          state_next     = IDLE;
          phase_next     = '0;
          bit_count_next = '0;
        end else begin
          // Any edge re-aligns the phase, even on the sample cycle itself.
          if (d_edge || (phase_reg == LAST_PHASE)) begin
            phase_next = '0;
          end else begin
            phase_next = phase_reg + 1'b1;
          end
          if (byte_int) begin
            bit_count_next = '0;
          end else if (shift_int) begin
            bit_count_next = bit_count_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next     = IDLE;
        phase_next     = '0;
        bit_count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_reg     <= '0;
      bit_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      bit_count_reg <= bit_count_next;
    end
  end

  assign shift_enable  = shift_int;
  assign byte_received = byte_int;
  assign bit_count     = bit_count_reg;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer: default instance plus a 4-clk/4-bit instance.
module tb_rx_bit_timer;
  import usb_rx_pkg::*;

  typedef struct {
    logic d;
    logic edge_end;
    logic se;
    logic br;
    logic err;
    int   cnt;
  } bit_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, edge_a = 1'b0, d_a = 1'b0, act_a = 1'b0;
  logic se_a, br_a, err_a;
  logic [3:0] cnt_a;
  logic rst_b = 1'b1, edge_b = 1'b0, d_b = 1'b0, act_b = 1'b0;
  logic se_b, br_b, err_b;
  logic [2:0] cnt_b;

  rx_bit_timer #(
    .CLKS_PER_BIT(8), .SAMPLE_POINT(3), .BITS_PER_BYTE(8), .STUFF_LEN(6)
  ) dut_a (
    .clk(clk), .rst(rst_a), .d_edge(edge_a), .d_orig(d_a), .rx_transfer_active(act_a),
    .shift_enable(se_a), .byte_received(br_a), .stuff_error(err_a), .bit_count(cnt_a)
  );

  rx_bit_timer #(
    .CLKS_PER_BIT(4), .SAMPLE_POINT(1), .BITS_PER_BYTE(4), .STUFF_LEN(6)
  ) dut_b (
    .clk(clk), .rst(rst_b), .d_edge(edge_b), .d_orig(d_b), .rx_transfer_active(act_b),
    .shift_enable(se_b), .byte_received(br_b), .stuff_error(err_b), .bit_count(cnt_b)
  );

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;
  int first_shift = -1;
  int s_se, s_br, s_err, s_cnt, s_phase, s_state, s_cycle;

  bit_vec_t va[30];
  bit_vec_t vb[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d: got %0d expected %0d", name, s_cycle, act, exp);
    end
  endtask

  // Drive one clock of inputs to the selected instance; outputs are sampled on the falling edge.
  task automatic cyc(input bit b, input logic r, input logic e, input logic d, input logic a);
    if (!b) begin
      rst_a = r; edge_a = e; d_a = d; act_a = a;
    end else begin
      rst_b = r; edge_b = e; d_b = d; act_b = a;
    end
    @(negedge clk);
    s_cycle = cycle_no;
    if (!b) begin
      s_se = int'(se_a); s_br = int'(br_a); s_err = int'(err_a); s_cnt = int'(cnt_a);
      s_phase = int'(dut_a.phase_reg); s_state = int'(dut_a.state_reg);
    end else begin
      s_se = int'(se_b); s_br = int'(br_b); s_err = int'(err_b); s_cnt = int'(cnt_b);
      s_phase = int'(dut_b.phase_reg); s_state = int'(dut_b.state_reg);
    end
    $display("cyc %0d dut=%0d rst=%0d edge=%0d d=%0d act=%0d -> se=%0d br=%0d err=%0d cnt=%0d",
             s_cycle, b, r, e, d, a, s_se, s_br, s_err, s_cnt);
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  task automatic quiet(input string name);
    chk(name, s_se + s_br + s_err, 0);
  endtask

  task automatic run_bit(input bit b, input bit_vec_t v, input int cpb, input int sp,
                         input string tag);
    for (int ph = 0; ph < cpb; ph++) begin
      cyc(b, 1'b0, (ph == cpb - 1) && v.edge_end, v.d, 1'b1);
      if (ph == sp) begin
        chk({tag, ".shift"}, s_se, int'(v.se));
        chk({tag, ".byte"}, s_br, int'(v.br));
        chk({tag, ".stuff_err"}, s_err, int'(v.err));
        chk({tag, ".bit_count"}, s_cnt, v.cnt);
        if (s_se != 0 && first_shift < 0) first_shift = s_cycle;
      end else begin
        quiet({tag, ".quiet"});
      end
    end
  endtask

  // Resync helper for dut_a: one cycle with d_orig=0, expected shift and bit_count.
  task automatic rs(input logic e, input int exp_se, input int exp_cnt, input string name);
    cyc(1'b0, 1'b0, e, 1'b0, 1'b1);
    chk({name, ".shift"}, s_se, exp_se);
    chk({name, ".other"}, s_br + s_err, 0);
    if (exp_se != 0) chk({name, ".bit_count"}, s_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 0x5A LSB first with an edge at each transition, then eight ones without edges.
    va[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    va[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    va[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    va[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    va[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4};
    va[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5};
    va[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6};
    va[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7};
    va[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    va[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    va[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    va[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    va[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    va[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    va[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6};
    va[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6};
    // Six ones then a correctly stuffed zero.
    for (int k = 16; k < 22; k++) va[k] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, k - 16};
    va[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6};
    // Five zeros before the mid-byte deassert, then one bit of the next packet.
    for (int k = 23; k < 28; k++) va[k] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, k - 23};
    va[28] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    va[29] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vb[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vb[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vb[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vb[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3};
    vb[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vb[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};

    // Reset: pulses off in the reset cycle and the one after.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    quiet("reset_cycle");
    cycle_no = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    quiet("post_reset");
    chk("post_reset.state", s_state, int'(IDLE));
    chk("post_reset.bit_count", s_cnt, 0);
    for (int i = 1; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      quiet("armed_wait");
    end
    chk("armed_wait.state", s_state, int'(ARMED));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    quiet("sync_edge");

    for (int k = 0; k < 8; k++) run_bit(1'b0, va[k], 8, 3, "byte5a");
    chk("byte5a.first_shift_cycle", first_shift, 14);
    for (int k = 8; k < 16; k++) run_bit(1'b0, va[k], 8, 3, "stuff_err");

    // Drop active, re-arm, and send six ones with a proper stuffed zero.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet("drop1");
    chk("drop1.bit_count", s_cnt, 7);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop1.cleared", s_cnt, 0);
    chk("drop1.state", s_state, int'(IDLE));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    quiet("sync2");
    for (int k = 16; k < 23; k++) run_bit(1'b0, va[k], 8, 3, "stuff_ok");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stuff_ok.bit_count_end", s_cnt, 6);
    quiet("stuff_ok.drop");

    // Deassert at bit_count 5 on the sample cycle itself.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 23; k < 28; k++) run_bit(1'b0, va[k], 8, 3, "pre_drop");
    for (int ph = 0; ph < 3; ph++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      quiet("pre_drop.tail");
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet("drop_at5.gated");
    chk("drop_at5.bit_count", s_cnt, 5);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      quiet("drop_at5.idle");
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      quiet("rearm_no_edge");
    end
    chk("rearm_no_edge.bit_count", s_cnt, 0);
    chk("rearm_no_edge.state", s_state, int'(ARMED));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_bit(1'b0, va[29], 8, 3, "new_packet");

    // Early edge at phase 5, then an edge on the sample cycle.
    rs(1'b0, 0, 0, "rs.p0");
    rs(1'b0, 0, 0, "rs.p1");
    rs(1'b0, 0, 0, "rs.p2");
    rs(1'b0, 1, 1, "rs.p3");
    rs(1'b0, 0, 0, "rs.p4");
    rs(1'b1, 0, 0, "rs.early_edge");
    rs(1'b0, 0, 0, "rs.after_edge");
    chk("rs.phase_reset", s_phase, 0);
    rs(1'b0, 0, 0, "rs.e2");
    rs(1'b0, 0, 0, "rs.e3");
    rs(1'b1, 1, 2, "rs.edge_plus4_same_cycle");
    rs(1'b0, 0, 0, "rs.after_same");
    chk("rs.same_phase_reset", s_phase, 0);
    rs(1'b0, 0, 0, "rs.old_schedule");
    rs(1'b0, 0, 0, "rs.s3");
    rs(1'b0, 1, 3, "rs.next_sample");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Small instance: 4 clks/bit, byte every 4 shifts, reset mid-byte.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    quiet("b.reset_cycle");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    quiet("b.post_reset");
    chk("b.post_reset.state", s_state, int'(IDLE));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    quiet("b.sync");
    for (int k = 0; k < 6; k++) run_bit(1'b1, vb[k], 4, 1, "b.bits");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    quiet("b.ph0");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    quiet("b.rst_on_sample");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    quiet("b.after_rst");
    chk("b.after_rst.state", s_state, int'(IDLE));
    chk("b.after_rst.bit_count", s_cnt, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    quiet("b.armed");
    chk("b.armed.state", s_state, int'(ARMED));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
